// File: rtl/var_cell.sv
// var_cell: per-variable assignment state for a hardware SAT solver.
// Tracks whether the variable is free, decided, implied or in conflict.
// Also tracks the decision level and value at which the variable was assigned.
// Optional feature: define VAR_CELL_PHASE_SAVE_EN to add phase saving.
// With phase saving, decisions reuse the last value the variable had
// before it was backtracked to FREE.
module var_cell #(
   parameter int unsigned LVL_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_i,
   input  logic [1:0]       wr_value_i,
   input  logic [LVL_W-1:0] wr_level_i,
   input  logic             decide_i,
   input  logic [1:0]       decide_value_i,
   input  logic [LVL_W-1:0] cur_level_i,
   input  logic [1:0]       imp_i,
   input  logic             backtrack_i,
   input  logic [LVL_W-1:0] bkt_level_i,
   output logic [2:0]       var_value_o,
   output logic [LVL_W-1:0] level_o,
   output logic             newimp_o,
   output logic             conflict_o
);

   typedef enum logic [1:0] {
      S_FREE     = 2'd0,
      S_DECIDED  = 2'd1,
      S_IMPLIED  = 2'd2,
      S_CONFLICT = 2'd3
   } state_t;

   state_t           r_state;
   state_t           r_prior;      // state kind held before entering CONFLICT
   logic [1:0]       r_value;      // value retained through CONFLICT
   logic [LVL_W-1:0] r_level;
   logic [2:0]       r_var_value;
   logic             r_newimp;
   logic             r_conflict;

   logic [1:0]       w_dec_val;
   logic             w_dec_ok;
   logic             w_bkt_clear;

   // A backtrack only unassigns a variable assigned strictly above the target level
   assign w_bkt_clear = (r_state != S_FREE) && (r_level > bkt_level_i);

`ifdef VAR_CELL_PHASE_SAVE_EN
   logic [1:0] r_phase;

   // Remember the last real polarity whenever a backtrack frees the variable
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_phase <= 2'b01;
      end else if (!wr_i && backtrack_i && w_bkt_clear && (^r_value)) begin
         r_phase <= r_value;
      end
   end

   assign w_dec_val = r_phase;
`else
   assign w_dec_val = decide_value_i;
`endif

   // Only a definite polarity (false or true) can be decided
   assign w_dec_ok = ^w_dec_val;

   // Assignment FSM; priority is write, then backtrack, then decide, then implication
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_FREE;
         r_prior     <= S_FREE;
         r_value     <= '0;
         r_level     <= '0;
         r_var_value <= '0;
         r_newimp    <= 1'b0;
         r_conflict  <= 1'b0;
      end else begin
         r_newimp <= 1'b0;
         if (wr_i) begin
            case (wr_value_i)
               2'd0: begin
                  r_state     <= S_FREE;
                  r_value     <= '0;
                  r_level     <= '0;
                  r_var_value <= '0;
                  r_conflict  <= 1'b0;
               end
               2'd3: begin
                  r_state     <= S_CONFLICT;
                  r_prior     <= S_FREE;
                  r_value     <= '0;
                  r_level     <= wr_level_i;
                  r_var_value <= 3'b110;
                  r_conflict  <= 1'b1;
               end
               default: begin
                  r_state     <= S_DECIDED;
                  r_value     <= wr_value_i;
                  r_level     <= wr_level_i;
                  r_var_value <= {wr_value_i, 1'b0};
                  r_conflict  <= 1'b0;
               end
            endcase
         end else if (backtrack_i) begin
            if (w_bkt_clear) begin
               r_state     <= S_FREE;
               r_value     <= '0;
               r_level     <= '0;
               r_var_value <= '0;
               r_conflict  <= 1'b0;
            end else if (r_state == S_CONFLICT) begin
               // Restore whatever the conflict interrupted; a conflict that
               // arose from FREE restores a clean FREE at level 0
               r_state     <= r_prior;
               r_var_value <= {r_value, (r_prior == S_IMPLIED)};
               r_conflict  <= 1'b0;
               if (r_prior == S_FREE) begin
                  r_level <= '0;
               end
            end
         end else begin
            unique case (r_state)
               S_FREE: begin
                  if (decide_i && w_dec_ok) begin
                     r_state     <= S_DECIDED;
                     r_value     <= w_dec_val;
                     r_level     <= cur_level_i;
                     r_var_value <= {w_dec_val, 1'b0};
                  end else if (imp_i == 2'd3) begin
                     r_state     <= S_CONFLICT;
                     r_prior     <= S_FREE;
                     r_value     <= '0;
                     r_level     <= cur_level_i;
                     r_var_value <= 3'b110;
                     r_conflict  <= 1'b1;
                  end else if (imp_i != 2'd0) begin
                     r_state     <= S_IMPLIED;
                     r_value     <= imp_i;
                     r_level     <= cur_level_i;
                     r_var_value <= {imp_i, 1'b1};
                     r_newimp    <= 1'b1;
                  end
               end
               S_DECIDED, S_IMPLIED: begin
                  if ((imp_i != 2'd0) && (imp_i != r_value)) begin
                     r_state     <= S_CONFLICT;
                     r_prior     <= r_state;
                     r_var_value <= 3'b110;
                     r_conflict  <= 1'b1;
                  end
               end
               S_CONFLICT: begin
                  // Held until backtrack or write
               end
            endcase
         end
      end
   end

   assign var_value_o = r_var_value;
   assign level_o     = r_level;
   assign newimp_o    = r_newimp;
   assign conflict_o  = r_conflict;

endmodule

// File: tb/tb_var_cell.sv
// Directed testbench for var_cell with hand-computed expectations.
module tb_var_cell;

   localparam int unsigned LVL_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             wr_i;
   logic [1:0]       wr_value_i;
   logic [LVL_W-1:0] wr_level_i;
   logic             decide_i;
   logic [1:0]       decide_value_i;
   logic [LVL_W-1:0] cur_level_i;
   logic [1:0]       imp_i;
   logic             backtrack_i;
   logic [LVL_W-1:0] bkt_level_i;
   logic [2:0]       var_value_o;
   logic [LVL_W-1:0] level_o;
   logic             newimp_o;
   logic             conflict_o;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   var_cell #(.LVL_W(LVL_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .wr_i           (wr_i),
      .wr_value_i     (wr_value_i),
      .wr_level_i     (wr_level_i),
      .decide_i       (decide_i),
      .decide_value_i (decide_value_i),
      .cur_level_i    (cur_level_i),
      .imp_i          (imp_i),
      .backtrack_i    (backtrack_i),
      .bkt_level_i    (bkt_level_i),
      .var_value_o    (var_value_o),
      .level_o        (level_o),
      .newimp_o       (newimp_o),
      .conflict_o     (conflict_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic idle();
      wr_i = 1'b0; wr_value_i = '0; wr_level_i = '0;
      decide_i = 1'b0; decide_value_i = '0; cur_level_i = '0;
      imp_i = '0; backtrack_i = 1'b0; bkt_level_i = '0;
   endtask

   // One rising edge, then settle before sampling
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      #1;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      #12;
      // Reset state
      check("rst_val",  16'(var_value_o), 16'h0);
      check("rst_lvl",  16'(level_o),     16'h0);
      check("rst_nimp", 16'(newimp_o),    16'h0);
      check("rst_conf", 16'(conflict_o),  16'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;

      // Decide true at level 3
      decide_i = 1'b1; decide_value_i = 2'd2; cur_level_i = 8'd3;
      step();
`ifdef VAR_CELL_PHASE_SAVE_EN
      check("dec_val", 16'(var_value_o), 16'h2);
`else
      check("dec_val", 16'(var_value_o), 16'h4);
`endif
      check("dec_lvl",  16'(level_o),  16'h3);
      check("dec_nimp", 16'(newimp_o), 16'h0);
      idle();

      // Decided true at level 2, opposing implication -> conflict
      wr_i = 1'b1; wr_value_i = 2'd2; wr_level_i = 8'd2;
      step();
      check("wr_val", 16'(var_value_o), 16'h4);
      check("wr_lvl", 16'(level_o),     16'h2);
      idle();
      imp_i = 2'd1;
      step();
      check("cf_val",  16'(var_value_o[2:1]), 16'h3);
      check("cf_conf", 16'(conflict_o),       16'h1);
      // Conflict ignores decide and implication
      decide_i = 1'b1; decide_value_i = 2'd1; imp_i = 2'd2;
      step();
      check("cf_hold", 16'(conflict_o), 16'h1);
      idle();
      // Backtrack to equal level restores the decision
      backtrack_i = 1'b1; bkt_level_i = 8'd2;
      step();
      check("bk_eq_val",  16'(var_value_o), 16'h4);
      check("bk_eq_conf", 16'(conflict_o),  16'h0);
      check("bk_eq_lvl",  16'(level_o),     16'h2);
      idle();
      // Matching implication on a decided variable changes nothing
      imp_i = 2'd2;
      step();
      check("same_val",  16'(var_value_o), 16'h4);
      check("same_nimp", 16'(newimp_o),    16'h0);
      check("same_conf", 16'(conflict_o),  16'h0);
      idle();

      // Asynchronous reset mid-operation
      @(negedge clk);
      rst = 1'b1;
      #2;
      check("arst_val", 16'(var_value_o), 16'h0);
      check("arst_lvl", 16'(level_o),     16'h0);
      rst = 1'b0;
      #1;

      // Implication from FREE: one-cycle newimp pulse
      imp_i = 2'd1; cur_level_i = 8'd5;
      step();
      check("imp_val",  16'(var_value_o), 16'h3);
      check("imp_lvl",  16'(level_o),     16'h5);
      check("imp_nimp", 16'(newimp_o),    16'h1);
      step();
      check("imp_nimp2", 16'(newimp_o),    16'h0);
      check("imp_val2",  16'(var_value_o), 16'h3);
      idle();

      // Implied at level 4, backtrack below it while deciding
      do_reset();
      imp_i = 2'd2; cur_level_i = 8'd4;
      step();
      check("imp4_val", 16'(var_value_o), 16'h5);
      idle();
      backtrack_i = 1'b1; bkt_level_i = 8'd3;
      decide_i = 1'b1; decide_value_i = 2'd2; cur_level_i = 8'd6;
      step();
      check("bk_gt_val", 16'(var_value_o), 16'h0);
      check("bk_gt_lvl", 16'(level_o),     16'h0);
      idle();

      // Decide and implication together: decide wins, implication next cycle
      do_reset();
      decide_i = 1'b1; decide_value_i = 2'd1; cur_level_i = 8'd2; imp_i = 2'd2;
      step();
      check("di_val",  16'(var_value_o), 16'h2);
      check("di_lvl",  16'(level_o),     16'h2);
      check("di_conf", 16'(conflict_o),  16'h0);
      decide_i = 1'b0;
      step();
      check("di_conf2", 16'(conflict_o), 16'h1);
      idle();
      // Backtrack out of a conflict above the target level frees it
      backtrack_i = 1'b1; bkt_level_i = 8'd1;
      step();
      check("bkc_val",  16'(var_value_o), 16'h0);
      check("bkc_conf", 16'(conflict_o),  16'h0);
      idle();

      // Write beats implication
      wr_i = 1'b1; wr_value_i = 2'd1; wr_level_i = 8'd7; imp_i = 2'd2;
      step();
      check("wi_val",  16'(var_value_o), 16'h2);
      check("wi_lvl",  16'(level_o),     16'h7);
      check("wi_conf", 16'(conflict_o),  16'h0);
      imp_i = 2'd0; wr_value_i = 2'd3;
      step();
      check("w3_conf", 16'(conflict_o), 16'h1);
      wr_value_i = 2'd0;
      step();
      check("w0_val",  16'(var_value_o), 16'h0);
      check("w0_conf", 16'(conflict_o),  16'h0);
      idle();

      // Phase behaviour after backtrack
      do_reset();
      wr_i = 1'b1; wr_value_i = 2'd2; wr_level_i = 8'd1;
      step();
      idle();
      backtrack_i = 1'b1; bkt_level_i = 8'd0;
      step();
      check("ph_free", 16'(var_value_o), 16'h0);
      idle();
      decide_i = 1'b1; decide_value_i = 2'd1; cur_level_i = 8'd1;
      step();
`ifdef VAR_CELL_PHASE_SAVE_EN
      check("ph_dec", 16'(var_value_o), 16'h4);
`else
      check("ph_dec", 16'(var_value_o), 16'h2);
`endif
      idle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
